// File: rtl/cpu_load_sequencer_pkg.sv
// Shared definitions for the boot/run sequencer.
// Contents:
//   state_t            controller states (3-bit encoding)
//   DEFAULT_BASE_ADDR  byte address of the first image word in data memory
//   DEFAULT_DONE_ADDR  byte address whose store marks program completion
//   WORD_SHIFT         word index to byte offset shift
//   addr_width()       ROM address width, at least 1 bit
//   word_to_byte()     base + word index scaled to bytes, wraps modulo 2^32
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_DONE_ADDR = 32'h0000_00FC;
  localparam int          WORD_SHIFT        = 2;

  // A one-word image still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [31:0] word_to_byte(input logic [31:0] base,
                                               input logic [31:0] idx);
    return base + (idx << WORD_SHIFT);
  endfunction

endpackage

// File: rtl/cpu_load_sequencer_if.sv
// Bus bundle between the sequencer, the image ROM, the data-memory external
// write port and the core's reset/store signals.
// Modports:
//   master  sequencer side: drives ROM address, memory write port, core reset;
//           receives ROM data and core store bus
//   slave   system side: the opposite directions
interface cpu_load_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int IMG_DEPTH = 32
);

  localparam int AW = addr_width(IMG_DEPTH);

  logic [AW-1:0] img_addr;
  logic [31:0]   img_data;
  logic          ext_mem_write;
  logic [31:0]   ext_data_adr;
  logic [31:0]   ext_write_data;
  logic          cpu_reset;
  logic          cpu_mem_write;
  logic [31:0]   cpu_data_adr;
  logic [31:0]   cpu_write_data;

  modport master (
    output img_addr, ext_mem_write, ext_data_adr, ext_write_data, cpu_reset,
    input  img_data, cpu_mem_write, cpu_data_adr, cpu_write_data
  );

  modport slave (
    input  img_addr, ext_mem_write, ext_data_adr, ext_write_data, cpu_reset,
    output img_data, cpu_mem_write, cpu_data_adr, cpu_write_data
  );

endinterface

// File: rtl/cpu_load_sequencer_sat_counter.sv
// Saturating up-counter with terminal-count flag.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous clear, dominates enable
//   enable        count up by one, stops once TERM is reached
//   count         current value
//   tc            high while count equals TERM
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == TERM);

  // Holding at TERM keeps tc asserted until the owner clears the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_load_sequencer.sv
// Boot and run controller for the single-cycle core and its data memory.
// On start it holds the core in reset, streams the image ROM into data memory
// one word per cycle, releases the core, then waits for a store to DONE_ADDR
// (captures its low byte into result) or for the watchdog to expire.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   start         single-cycle pulse, honoured in IDLE/DONE/TOUT only
//   bus           master side of cpu_load_sequencer_if (ROM, memory port, core)
//   result        low byte of the completion store
//   busy          high in LOAD or RUN
//   done          high in DONE
//   timeout       high in TOUT
module cpu_load_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int          IMG_DEPTH   = 32,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [31:0] DONE_ADDR   = DEFAULT_DONE_ADDR,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  cpu_load_sequencer_if.master        bus,
  output logic [7:0]                  result,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);

  localparam int AW = addr_width(IMG_DEPTH);
  localparam int WW = $clog2(IMG_DEPTH + 1);
  localparam int RW = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  logic [WW-1:0]   word_cnt;
  logic            word_tc;
  logic [RW-1:0]   run_cnt_unused;
  logic            run_tc;
  logic [31:0]     word_idx;
  logic            start_ok;
  logic            completion;
  logic            data_unused;

  assign word_idx    = 32'(word_cnt);
  assign start_ok    = start && (state == IDLE || state == DONE || state == TOUT);
  assign completion  = bus.cpu_mem_write && (bus.cpu_data_adr == DONE_ADDR);
  assign data_unused = ^bus.cpu_write_data[31:8];

  // The ROM output register already aligns each word with its write strobe,
  // so write data is taken straight from the ROM while the strobe is high and
  // forced to zero otherwise.
  assign bus.ext_write_data = bus.ext_mem_write ? bus.img_data : 32'h0;

  // Word counter: value k during the k-th LOAD cycle, terminal at IMG_DEPTH,
  // i.e. the cycle after the last write has been issued.
  sat_counter #(
    .WIDTH (WW),
    .TERM  (WW'(IMG_DEPTH))
  ) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_ok),
    .enable  (state == LOAD),
    .count   (word_cnt),
    .tc      (word_tc)
  );

  // Run watchdog: cleared on the LOAD->RUN edge so it reads 0 in the first
  // RUN cycle; terminal one below TIMEOUT_CYC gives exactly TIMEOUT_CYC RUN
  // cycles before the abort.
  sat_counter #(
    .WIDTH (RW),
    .TERM  (RW'(TIMEOUT_CYC - 1))
  ) u_run_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == LOAD) && word_tc),
    .enable  (state == RUN),
    .count   (run_cnt_unused),
    .tc      (run_tc)
  );

  // Controller FSM with registered outputs. In LOAD the write for word k is
  // issued on the edge ending cycle k, while the ROM address steps to k+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      bus.cpu_reset     <= 1'b1;
      bus.ext_mem_write <= 1'b0;
      bus.ext_data_adr  <= 32'h0;
      bus.img_addr      <= '0;
      result            <= 8'h0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE, TOUT: begin
          bus.cpu_reset     <= 1'b1;
          bus.ext_mem_write <= 1'b0;
          if (start) begin
            state        <= LOAD;
            bus.img_addr <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        LOAD: begin
          if (word_tc) begin
            state             <= RUN;
            bus.ext_mem_write <= 1'b0;
            bus.cpu_reset     <= 1'b0;
          end else begin
            bus.ext_mem_write <= 1'b1;
            bus.ext_data_adr  <= word_to_byte(BASE_ADDR, word_idx);
            if (word_idx + 32'd1 < 32'(IMG_DEPTH)) begin
              bus.img_addr <= AW'(word_idx + 32'd1);
            end
          end
        end
        RUN: begin
          if (completion) begin
            state         <= DONE;
            result        <= bus.cpu_write_data[7:0];
            bus.cpu_reset <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b1;
          end else if (run_tc) begin
            state         <= TOUT;
            bus.cpu_reset <= 1'b1;
            busy          <= 1'b0;
            timeout       <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.cpu_reset <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_load_sequencer.sv
// Directed testbench for cpu_load_sequencer (IMG_DEPTH=4, TIMEOUT_CYC=8).
// A vector table drives start and the core store bus cycle by cycle and lists
// the outputs expected after each clock edge; hand-written sequences cover
// asynchronous reset in the middle of LOAD and the reload that follows.
module tb_cpu_load_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [4];

  typedef struct packed {
    logic        start;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        exp_wr;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    logic [1:0]  exp_img;
    logic        exp_crst;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_tout;
    logic [7:0]  exp_res;
  } vec_t;

  vec_t vecs[$];

  cpu_load_sequencer_if #(.IMG_DEPTH(4)) bus ();

  cpu_load_sequencer #(
    .IMG_DEPTH   (4),
    .BASE_ADDR   (32'h0000_0000),
    .DONE_ADDR   (32'h0000_00FC),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image ROM: data appears one cycle after the address.
  always_ff @(posedge clk) bus.img_data <= rom[bus.img_addr];

  // Hard bound on simulation time in case the sequencing stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input string name,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic addVec(input logic st, input logic mw, input logic [31:0] adr,
                        input logic [31:0] wd, input logic wr, input logic [31:0] eadr,
                        input logic [31:0] edata, input logic [1:0] img,
                        input logic crst, input logic bsy, input logic dn,
                        input logic to, input logic [7:0] res);
    vec_t v;
    v = '{start: st, mw: mw, adr: adr, wd: wd, exp_wr: wr, exp_adr: eadr,
          exp_data: edata, exp_img: img, exp_crst: crst, exp_busy: bsy,
          exp_done: dn, exp_tout: to, exp_res: res};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start              = v.start;
    bus.cpu_mem_write  = v.mw;
    bus.cpu_data_adr   = v.adr;
    bus.cpu_write_data = v.wd;
    @(posedge clk);
    #1;
  endtask

  // Address and data of the memory port only matter while the strobe is high.
  task automatic checkOutput(input vec_t v, input string tag);
    checkField(tag, "ext_mem_write", 32'(bus.ext_mem_write), 32'(v.exp_wr));
    if (v.exp_wr) begin
      checkField(tag, "ext_data_adr", bus.ext_data_adr, v.exp_adr);
      checkField(tag, "ext_write_data", bus.ext_write_data, v.exp_data);
    end
    checkField(tag, "img_addr", 32'(bus.img_addr), 32'(v.exp_img));
    checkField(tag, "cpu_reset", 32'(bus.cpu_reset), 32'(v.exp_crst));
    checkField(tag, "busy", 32'(busy), 32'(v.exp_busy));
    checkField(tag, "done", 32'(done), 32'(v.exp_done));
    checkField(tag, "timeout", 32'(timeout), 32'(v.exp_tout));
    checkField(tag, "result", 32'(result), 32'(v.exp_res));
  endtask

  // One full load: LOAD cycle 0 (start accepted), four writes, first RUN cycle.
  task automatic addLoad(input logic [7:0] res, input logic st_c1, input logic st_c3);
    addVec(1, 0, 0, 0, 0, 0,     0,  0, 1, 1, 0, 0, res);
    addVec(st_c1, 0, 0, 0, 1, 32'h0, 11, 1, 1, 1, 0, 0, res);
    addVec(0, 0, 0, 0, 1, 32'h4, 22, 2, 1, 1, 0, 0, res);
    addVec(st_c3, 0, 0, 0, 1, 32'h8, 33, 3, 1, 1, 0, 0, res);
    addVec(0, 0, 0, 0, 1, 32'hC, 44, 3, 1, 1, 0, 0, res);
    addVec(0, 0, 0, 0, 0, 0,     0,  3, 0, 1, 0, 0, res);
  endtask

  initial begin
    rom[0] = 32'd11;
    rom[1] = 32'd22;
    rom[2] = 32'd33;
    rom[3] = 32'd44;

    reset_n            = 1'b0;
    start              = 1'b0;
    bus.cpu_mem_write  = 1'b0;
    bus.cpu_data_adr   = 32'h0;
    bus.cpu_write_data = 32'h0;

    // Load, then completion after an ignored store to 0xF8.
    addLoad(8'h00, 0, 0);
    addVec(0, 1, 32'hF8, 32'h99,        0, 0, 0, 3, 0, 1, 0, 0, 8'h00);
    addVec(0, 1, 32'hFC, 32'h1234_56A5, 0, 0, 0, 3, 1, 0, 1, 0, 8'hA5);
    addVec(0, 0, 0, 0,                  0, 0, 0, 3, 1, 0, 1, 0, 8'hA5);
    // Restart from DONE with stray starts in LOAD and RUN, then watchdog abort.
    addLoad(8'hA5, 1, 1);
    addVec(1, 1, 32'h100, 32'hFF, 0, 0, 0, 3, 0, 1, 0, 0, 8'hA5);
    for (int r = 2; r <= 7; r++) addVec(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 8'hA5);
    addVec(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 8'hA5);
    addVec(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 8'hA5);
    // Restart from TOUT; completion lands on the watchdog's terminal cycle.
    addLoad(8'hA5, 0, 0);
    for (int r = 1; r <= 7; r++) addVec(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 8'hA5);
    addVec(0, 1, 32'hFC, 32'h0000_005A, 0, 0, 0, 3, 1, 0, 1, 0, 8'h5A);

    // Reset values while reset_n is held low.
    repeat (2) @(posedge clk);
    #1;
    checkField("reset", "cpu_reset", 32'(bus.cpu_reset), 32'h1);
    checkField("reset", "ext_mem_write", 32'(bus.ext_mem_write), 32'h0);
    checkField("reset", "ext_data_adr", bus.ext_data_adr, 32'h0);
    checkField("reset", "ext_write_data", bus.ext_write_data, 32'h0);
    checkField("reset", "img_addr", 32'(bus.img_addr), 32'h0);
    checkField("reset", "result", 32'(result), 32'h0);
    checkField("reset", "busy", 32'(busy), 32'h0);
    checkField("reset", "done", 32'(done), 32'h0);
    checkField("reset", "timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset two cycles into a fresh LOAD.
    @(negedge clk);
    bus.cpu_mem_write = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkField("midload", "ext_mem_write", 32'(bus.ext_mem_write), 32'h1);
    checkField("midload", "ext_data_adr", bus.ext_data_adr, 32'h4);
    #1;
    reset_n = 1'b0;
    #1;
    checkField("async_rst", "ext_mem_write", 32'(bus.ext_mem_write), 32'h0);
    checkField("async_rst", "cpu_reset", 32'(bus.cpu_reset), 32'h1);
    checkField("async_rst", "busy", 32'(busy), 32'h0);
    checkField("async_rst", "img_addr", 32'(bus.img_addr), 32'h0);
    checkField("async_rst", "result", 32'(result), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkField("idle", "busy", 32'(busy), 32'h0);
    checkField("idle", "cpu_reset", 32'(bus.cpu_reset), 32'h1);
    checkField("idle", "done", 32'(done), 32'h0);

    // Reload restarts from word 0.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkField("reload", "ext_mem_write", 32'(bus.ext_mem_write), 32'h1);
    checkField("reload", "ext_data_adr", bus.ext_data_adr, 32'h0);
    checkField("reload", "ext_write_data", bus.ext_write_data, 32'd11);
    checkField("reload", "img_addr", 32'(bus.img_addr), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    checkField("reload_run", "cpu_reset", 32'(bus.cpu_reset), 32'h0);
    checkField("reload_run", "busy", 32'(busy), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
